// File: rtl/comma_aligner.sv
// Serial-to-10b comma aligner: finds the K28.5 boundary in a bit stream,
// qualifies lock over several aligned commas and emits aligned code groups.
module comma_aligner #(
    parameter int LOCK_CNT       = 3,
    parameter int UNLOCK_CNT     = 2,
    parameter int SEARCH_TIMEOUT = 16
) (
    input  logic       i_Rclk,
    input  logic       i_rst_n,
    input  logic       i_bit,
    input  logic       i_bit_valid,
    output logic [9:0] o_word,
    output logic       o_word_valid,
    output logic       o_is_comma,
    output logic       o_locked,
    output logic       o_align_err
);
    localparam int CW = $clog2(LOCK_CNT + 1);
    localparam int TW = $clog2(SEARCH_TIMEOUT + 1);
    localparam int MW = $clog2(UNLOCK_CNT + 1);
    localparam logic [CW-1:0] LOCK_MAX  = CW'(LOCK_CNT);
    localparam logic [TW-1:0] TMO_MAX   = TW'(SEARCH_TIMEOUT);
    localparam logic [MW-1:0] UNLK_MAX  = MW'(UNLOCK_CNT);

    typedef enum logic [1:0] {UNLOCKED, LOCKING, LOCKED} state_t;

    state_t        state, state_nxt;
    logic [9:0]    window, window_nxt, win_shift;
    logic [3:0]    bit_cnt, bit_cnt_nxt;
    logic [CW-1:0] comma_cnt, comma_cnt_nxt;
    logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;
    logic [MW-1:0] mis_cnt, mis_cnt_nxt;
    logic [9:0]    word_nxt;
    logic          vld_nxt, is_comma_nxt, err_nxt;
    logic          comma, boundary;

    assign win_shift = {i_bit, window[9:1]};
    assign comma     = (win_shift == 10'h17C) || (win_shift == 10'h283);
    assign boundary  = (bit_cnt == 4'd9);

    always_comb begin
        state_nxt     = state;
        window_nxt    = window;
        bit_cnt_nxt   = bit_cnt;
        comma_cnt_nxt = comma_cnt;
        tmo_cnt_nxt   = tmo_cnt;
        mis_cnt_nxt   = mis_cnt;
        word_nxt      = o_word;
        is_comma_nxt  = o_is_comma;
        vld_nxt       = 1'b0;
        err_nxt       = 1'b0;
        if (i_bit_valid) begin
            window_nxt  = win_shift;
            bit_cnt_nxt = boundary ? 4'd0 : bit_cnt + 4'd1;
            case (state)
                UNLOCKED: begin
                    if (comma) begin
                        bit_cnt_nxt   = 4'd0;
                        comma_cnt_nxt = CW'(1);
                        tmo_cnt_nxt   = '0;
                        state_nxt     = LOCKING;
                    end
                end
                LOCKING: begin
                    if (boundary) begin
                        if (comma) begin
                            tmo_cnt_nxt = '0;
                            if (comma_cnt + CW'(1) >= LOCK_MAX) begin
                                // The comma that completes lock is emitted as a word.
                                comma_cnt_nxt = LOCK_MAX;
                                mis_cnt_nxt   = '0;
                                state_nxt     = LOCKED;
                                word_nxt      = win_shift;
                                is_comma_nxt  = 1'b1;
                                vld_nxt       = 1'b1;
                            end else begin
                                comma_cnt_nxt = comma_cnt + CW'(1);
                            end
                        end else if (tmo_cnt + TW'(1) >= TMO_MAX) begin
                            tmo_cnt_nxt   = '0;
                            comma_cnt_nxt = '0;
                            state_nxt     = UNLOCKED;
                        end else begin
                            tmo_cnt_nxt = tmo_cnt + TW'(1);
                        end
                    end else if (comma) begin
                        bit_cnt_nxt   = 4'd0;
                        comma_cnt_nxt = CW'(1);
                        tmo_cnt_nxt   = '0;
                    end
                end
                LOCKED: begin
                    if (boundary) begin
                        word_nxt     = win_shift;
                        is_comma_nxt = comma;
                        vld_nxt      = 1'b1;
                        if (comma) mis_cnt_nxt = '0;
                    end else if (comma) begin
                        // Off-boundary comma: flag it but keep the current boundary.
                        err_nxt = 1'b1;
                        if (mis_cnt + MW'(1) >= UNLK_MAX) begin
                            state_nxt     = UNLOCKED;
                            bit_cnt_nxt   = 4'd0;
                            comma_cnt_nxt = '0;
                            tmo_cnt_nxt   = '0;
                            mis_cnt_nxt   = '0;
                        end else begin
                            mis_cnt_nxt = mis_cnt + MW'(1);
                        end
                    end
                end
                default: state_nxt = UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge i_Rclk) begin
        if (!i_rst_n) begin
            state        <= UNLOCKED;
            window       <= '0;
            bit_cnt      <= '0;
            comma_cnt    <= '0;
            tmo_cnt      <= '0;
            mis_cnt      <= '0;
            o_word       <= '0;
            o_word_valid <= 1'b0;
            o_is_comma   <= 1'b0;
            o_align_err  <= 1'b0;
        end else begin
            state        <= state_nxt;
            window       <= window_nxt;
            bit_cnt      <= bit_cnt_nxt;
            comma_cnt    <= comma_cnt_nxt;
            tmo_cnt      <= tmo_cnt_nxt;
            mis_cnt      <= mis_cnt_nxt;
            o_word       <= word_nxt;
            o_word_valid <= vld_nxt;
            o_is_comma   <= is_comma_nxt;
            o_align_err  <= err_nxt;
        end
    end

    assign o_locked = (state == LOCKED);
endmodule

// File: tb/tb_comma_aligner.sv
// Directed bench for comma_aligner: lock, offset lock, slip/unlock, timeout,
// gapped valid and mid-word reset, against hand-computed expectations.
module tb_comma_aligner;
    logic       i_Rclk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_bit = 1'b0;
    logic       i_bit_valid = 1'b0;
    logic [9:0] o_word;
    logic       o_word_valid, o_is_comma, o_locked, o_align_err;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int last_strobe = -1000;
    int strobe_cnt = 0;
    int sc;
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];

    comma_aligner dut (
        .i_Rclk(i_Rclk), .i_rst_n(i_rst_n), .i_bit(i_bit), .i_bit_valid(i_bit_valid),
        .o_word(o_word), .o_word_valid(o_word_valid), .o_is_comma(o_is_comma),
        .o_locked(o_locked), .o_align_err(o_align_err)
    );

    always #5 i_Rclk = ~i_Rclk;
    always @(posedge i_Rclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Strobe monitor: spacing, locked qualification, and a log of emitted words.
    always @(negedge i_Rclk) begin
        if (i_rst_n && o_word_valid) begin
            chk("strobe_gap>=10", 32'(cyc - last_strobe >= 10), 32'd1);
            chk("strobe_when_locked", 32'(o_locked), 32'd1);
            last_strobe = cyc;
            strobe_cnt++;
            got_q.push_back(o_word);
        end
    end

    task automatic send_bit(input logic b);
        i_bit = b;
        i_bit_valid = 1'b1;
        @(negedge i_Rclk);
        i_bit_valid = 1'b0;
    endtask

    task automatic send_word(input logic [9:0] w);
        for (int i = 0; i < 10; i++) send_bit(w[i]);
    endtask

    task automatic idle(input int n);
        i_bit_valid = 1'b0;
        repeat (n) @(negedge i_Rclk);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_bit_valid = 1'b0;
        repeat (2) @(negedge i_Rclk);
        i_rst_n = 1'b1;
    endtask

    task automatic send_word_gapped(input logic [9:0] w);
        for (int i = 0; i < 10; i++) begin
            while ($urandom_range(0, 1) == 0) idle(1);
            send_bit(w[i]);
        end
    endtask

    initial begin
        logic [9:0] data_w [5];
        data_w = '{10'h2A5, 10'h155, 10'h333, 10'h0CC, 10'h1A6};
        @(negedge i_Rclk);

        // Reset state
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_Rclk);
        chk("rst_word", 32'(o_word), 32'h0);
        chk("rst_valid", 32'(o_word_valid), 32'h0);
        chk("rst_comma", 32'(o_is_comma), 32'h0);
        chk("rst_locked", 32'(o_locked), 32'h0);
        chk("rst_err", 32'(o_align_err), 32'h0);
        i_rst_n = 1'b1;

        // Four RD- commas back to back: lock on the third, emit third and fourth
        send_word(10'h17C);
        chk("t1_w1_locked", 32'(o_locked), 32'h0);
        send_word(10'h17C);
        chk("t1_w2_locked", 32'(o_locked), 32'h0);
        chk("t1_w2_valid", 32'(o_word_valid), 32'h0);
        send_word(10'h17C);
        chk("t1_w3_locked", 32'(o_locked), 32'h1);
        chk("t1_w3_valid", 32'(o_word_valid), 32'h1);
        chk("t1_w3_word", 32'(o_word), 32'h17C);
        chk("t1_w3_comma", 32'(o_is_comma), 32'h1);
        send_word(10'h17C);
        chk("t1_w4_valid", 32'(o_word_valid), 32'h1);
        chk("t1_w4_word", 32'(o_word), 32'h17C);
        idle(1);
        chk("t1_strobe_one_cycle", 32'(o_word_valid), 32'h0);

        // Seven junk bits, then alternating-disparity commas and a data word
        do_reset();
        send_bit(1); send_bit(0); send_bit(1); send_bit(1);
        send_bit(0); send_bit(0); send_bit(1);
        send_word(10'h17C);
        send_word(10'h283);
        chk("t2_pre_locked", 32'(o_locked), 32'h0);
        send_word(10'h17C);
        chk("t2_locked", 32'(o_locked), 32'h1);
        chk("t2_lock_word", 32'(o_word), 32'h17C);
        send_word(10'h2A5);
        chk("t2_data_valid", 32'(o_word_valid), 32'h1);
        chk("t2_data_word", 32'(o_word), 32'h2A5);
        chk("t2_data_comma", 32'(o_is_comma), 32'h0);

        // Three-bit slip while locked: first misaligned comma errs, second unlocks
        send_bit(1); send_bit(0); send_bit(1);
        send_word(10'h17C);
        chk("t3_err1", 32'(o_align_err), 32'h1);
        chk("t3_err1_locked", 32'(o_locked), 32'h1);
        chk("t3_err1_novalid", 32'(o_word_valid), 32'h0);
        send_word(10'h17C);
        chk("t3_err2", 32'(o_align_err), 32'h1);
        chk("t3_unlocked", 32'(o_locked), 32'h0);
        send_word(10'h17C);
        send_word(10'h17C);
        chk("t3_relock_pending", 32'(o_locked), 32'h0);
        send_word(10'h17C);
        chk("t3_relocked", 32'(o_locked), 32'h1);
        chk("t3_relock_valid", 32'(o_word_valid), 32'h1);

        // 15 non-comma words keep LOCKING alive: two more commas complete lock
        do_reset();
        sc = strobe_cnt;
        send_word(10'h17C);
        for (int i = 0; i < 15; i++) send_word(10'h2A5);
        send_word(10'h17C);
        send_word(10'h17C);
        chk("t4_tmo15_locked", 32'(o_locked), 32'h1);
        // 16 non-comma words time out: two commas are not enough any more
        do_reset();
        idle(1);
        sc = strobe_cnt;
        send_word(10'h17C);
        for (int i = 0; i < 16; i++) send_word(10'h2A5);
        idle(1);
        chk("t4_no_strobe", 32'(strobe_cnt - sc), 32'h0);
        chk("t4_tmo16_locked", 32'(o_locked), 32'h0);
        send_word(10'h17C);
        send_word(10'h17C);
        chk("t4_after2_locked", 32'(o_locked), 32'h0);
        send_word(10'h17C);
        chk("t4_after3_locked", 32'(o_locked), 32'h1);

        // Random 50% bit-valid while locked: emitted stream must be bit-exact
        do_reset();
        idle(1);
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < 3; i++) send_word(10'h17C);
        exp_q.push_back(10'h17C);
        for (int i = 0; i < 5; i++) begin
            send_word_gapped(data_w[i]);
            exp_q.push_back(data_w[i]);
        end
        idle(15);
        chk("t5_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("t5_word%0d", i), 32'(got_q[i]), 32'(exp_q[i]));

        // Reset at bit 5 of a locked word: outputs cleared, partial word dropped
        do_reset();
        for (int i = 0; i < 3; i++) send_word(10'h17C);
        chk("t6_locked", 32'(o_locked), 32'h1);
        for (int i = 0; i < 5; i++) send_bit(data_w[0][i]);
        i_rst_n = 1'b0;
        i_bit = 1'b1;
        i_bit_valid = 1'b1;
        @(negedge i_Rclk);
        i_rst_n = 1'b1;
        i_bit_valid = 1'b0;
        chk("t6_word", 32'(o_word), 32'h0);
        chk("t6_valid", 32'(o_word_valid), 32'h0);
        chk("t6_comma", 32'(o_is_comma), 32'h0);
        chk("t6_locked0", 32'(o_locked), 32'h0);
        chk("t6_err", 32'(o_align_err), 32'h0);
        sc = strobe_cnt;
        idle(20);
        chk("t6_no_strobe", 32'(strobe_cnt - sc), 32'h0);
        for (int i = 0; i < 3; i++) send_word(10'h17C);
        chk("t6_relock", 32'(o_locked), 32'h1);

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/comma_aligner.md
COMMA_ALIGNER -- requirements
Module: comma_aligner

Interface
REQ-001 The block SHALL have parameter LOCK_CNT, default 3: consecutive boundary-aligned commas required to lock.
REQ-002 The block SHALL have parameter UNLOCK_CNT, default 2: misaligned commas, with no aligned comma between them, that force loss of lock.
REQ-003 The block SHALL have parameter SEARCH_TIMEOUT, default 16: words allowed in LOCKING without an aligned comma before returning to UNLOCKED.
REQ-004 The block SHALL have port i_Rclk, input, 1 bit: sole clock, rising edge.
REQ-005 The block SHALL have port i_rst_n, input, 1 bit: reset, synchronous, active-low, sampled on i_Rclk.
REQ-006 The block SHALL have port i_bit, input, 1 bit: serial line bit from the receive FIFO.
REQ-007 The block SHALL have port i_bit_valid, input, 1 bit: i_bit is accepted on an edge where this is high.
REQ-008 The block SHALL have port o_word, output, 10 bits: aligned code group; the first-received bit is in [0] and the last in [9].
REQ-009 The block SHALL have port o_word_valid, output, 1 bit: one-cycle strobe qualifying o_word.
REQ-010 The block SHALL have port o_is_comma, output, 1 bit: qualified by o_word_valid; the emitted word is a comma.
REQ-011 The block SHALL have port o_locked, output, 1 bit: high while the state is LOCKED.
REQ-012 The block SHALL have port o_align_err, output, 1 bit: one-cycle pulse when a comma is seen off-boundary in LOCKED.

Function
REQ-013 The block SHALL shift right on each accepted bit: i_bit enters window[9] and window[8:0] <= window[9:1]; with i_bit_valid low, the window and all counters SHALL hold.
REQ-014 The block SHALL treat the post-shift window as a comma when it equals 10'h17C (K28.5, RD-) or 10'h283 (K28.5, RD+); no other value SHALL be treated as a comma.
REQ-015 The block SHALL keep a 4-bit bit counter (0..9): a boundary occurs on the accepted bit for which the counter reads 9, after which the counter wraps to 0; an off-boundary bit is any other count.
REQ-016 The block SHALL implement a state machine with states UNLOCKED, LOCKING and LOCKED.
REQ-017 In UNLOCKED, the block SHALL check for a comma on every accepted bit; on a match it SHALL set the bit counter to 0, set the comma count to 1, clear the word timeout, and go to LOCKING.
REQ-018 In LOCKING, an aligned comma at a boundary SHALL increment the comma count and clear the timeout; when the count reaches LOCK_CNT the block SHALL go to LOCKED on that same edge.
REQ-019 In LOCKING, a non-comma word at a boundary SHALL increment the timeout; when the timeout reaches SEARCH_TIMEOUT the block SHALL return to UNLOCKED.
REQ-020 In LOCKING, an off-boundary comma SHALL re-align: bit counter to 0, comma count to 1, timeout cleared, state stays LOCKING.
REQ-021 In LOCKED, every boundary SHALL emit a word: o_word <= window and o_word_valid = 1 on the edge after the completing bit, with o_is_comma set per REQ-014.
REQ-022 The comma that completes lock per REQ-018 SHALL itself be emitted, giving o_word_valid and o_locked high in the same cycle.
REQ-023 In LOCKED, an off-boundary comma SHALL pulse o_align_err and increment the misalign count, and it SHALL NOT emit a word or move the boundary.
REQ-024 In LOCKED, the block SHALL go to UNLOCKED when the misalign count reaches UNLOCK_CNT, clearing all counters; any word still being assembled SHALL be discarded.
REQ-025 In LOCKED, an aligned comma SHALL clear the misalign count.
REQ-026 The block SHALL assert o_word_valid only in LOCKED, and never on two consecutive edges unless i_bit_valid supplied 10 bits between them; the minimum spacing is 10 cycles.
REQ-027 All counters SHALL saturate and not wrap: comma count at LOCK_CNT, timeout at SEARCH_TIMEOUT, misalign count at UNLOCK_CNT.
REQ-028 When a boundary and a comma coincide, the boundary classification (aligned) SHALL take precedence over the off-boundary rules.

Reset
REQ-029 When i_rst_n is low at a rising edge, the block SHALL set: window = 0, bit counter = 0, all counts = 0, state = UNLOCKED.
REQ-030 Under the same reset, the block SHALL drive o_word = 0, o_word_valid = 0, o_is_comma = 0, o_locked = 0 and o_align_err = 0.
REQ-031 Reset SHALL take priority over i_bit_valid; a reset mid-word or while LOCKED SHALL abort the word with no strobe, and the first accepted bit after release SHALL enter a cleared window.

Verification
REQ-032 The bench SHALL drive 4 x K28.5 RD- (10'h17C, LSB first), continuous valid -> LOCKING after 10 bits; o_locked rises with the first o_word_valid at word 3 (o_word = 10'h17C, o_is_comma = 1); word 4 is also emitted.
REQ-033 The bench SHALL drive 7 junk bits, then alternating 10'h17C / 10'h283 x3, then data 10'h2A5 -> lock is achieved at the correct offset, and 10'h2A5 is emitted with o_is_comma = 0.
REQ-034 While LOCKED, the bench SHALL insert a 3-bit slip and then commas -> o_align_err pulses on the first off-boundary comma; after the second, the state is UNLOCKED and o_locked = 0; re-lock follows after 3 more commas.
REQ-035 The bench SHALL send one comma, then 16 non-comma words -> the block returns to UNLOCKED after word 16, and no o_word_valid is ever asserted.
REQ-036 While LOCKED, the bench SHALL toggle i_bit_valid randomly at 50% -> emitted words match the sent sequence bit-exactly, with strobe spacing of at least 10 cycles.
REQ-037 The bench SHALL assert i_rst_n = 0 for 1 cycle at bit 5 of a LOCKED word -> all outputs are 0 the next cycle, with no strobe for the partial word.
